load_store_queue: RTL
=====================

LOAD_STORE_QUEUE -- requirements
Module: load_store_queue

Interface
REQ-001 SHALL have parameter DATA_W, default 16, data width.
REQ-002 SHALL have parameter ADDR_W, default 16, address width.
REQ-003 SHALL have parameter TAG_W, default 6, ROB tag width.
REQ-004 SHALL have parameter SB_DEPTH, default 8, store-buffer entries (power of 2, >=2).
REQ-005 SHALL have parameter LOAD_LAT, default 3, cycles from load accept to result (>=1).
REQ-006 SHALL have parameter COMMIT_W, default 2, width of per-cycle store-commit count.
REQ-007 SHALL have ports: clk in 1, one clock; rst_n in 1, reset asynchronous, active-low.
REQ-008 SHALL have ports: flush in 1, squash speculative state; commit_cnt in COMMIT_W, stores retired by ROB this cycle.
REQ-009 SHALL have ports: in_valid in 1; in_ready out 1; in_is_ld in 1; in_addr in ADDR_W; in_data in DATA_W; in_tag in TAG_W.
REQ-010 SHALL have ports: mem_rd_valid out 1; mem_rd_addr out ADDR_W; mem_rdata in DATA_W (valid LOAD_LAT cycles after mem_rd_valid).
REQ-011 SHALL have ports: mem_wr_valid out 1; mem_wr_addr out ADDR_W; mem_wr_data out DATA_W.
REQ-012 SHALL have ports: res_valid out 1; res_tag out TAG_W; res_data out DATA_W.

Function
REQ-013 Op SHALL be accepted when in_valid && in_ready && !flush; one op per cycle maximum.
REQ-014 in_ready SHALL be 0 when store buffer holds SB_DEPTH entries, for loads and stores alike; computed from registered count only (no same-cycle drain bypass).
REQ-015 Accepted store SHALL be written at store-buffer tail as uncommitted {addr, data}.
REQ-016 commit_cnt SHALL mark that many oldest uncommitted entries committed, in program order, same edge.
REQ-017 Oldest committed entry SHALL drive mem_wr_valid/addr/data combinationally and be freed every cycle it is presented (memory write never stalls).
REQ-018 Accepted load SHALL search all valid store-buffer entries by full-address equality; youngest matching entry SHALL win (forward).
REQ-019 Entry being drained in the load's accept cycle SHALL still be searched.
REQ-020 On forwarding miss, mem_rd_valid SHALL be 1 with mem_rd_addr=in_addr in the accept cycle; on hit, mem_rd_valid SHALL be 0.
REQ-021 Load SHALL traverse a LOAD_LAT-stage pipe carrying {valid, tag, hit, fwd_data}; result SHALL appear exactly LOAD_LAT cycles after accept.
REQ-022 res_data SHALL be fwd_data on hit, else mem_rdata sampled at the output stage; res_valid high one cycle per load.
REQ-023 Stores SHALL produce no res_valid.
REQ-024 flush SHALL clear all load-pipe valid bits and all uncommitted store entries; committed-undrained entries SHALL survive and keep draining.
REQ-025 flush coinciding with in_valid SHALL drop the op; flush coinciding with commit_cnt SHALL apply the commit first, then discard the rest.
REQ-026 Pointers SHALL wrap modulo SB_DEPTH; count width clog2(SB_DEPTH)+1 so full and empty are distinct.
REQ-027 commit_cnt exceeding uncommitted-entry count is illegal; design SHALL clamp to that count.

Reset
REQ-028 rst_n low SHALL asynchronously clear all pointers, counts, entry valids (including committed entries) and pipe valids.
REQ-029 During/after reset: in_ready=1, mem_rd_valid=0, mem_wr_valid=0, res_valid=0, all data/addr/tag outputs 0.
REQ-030 Reset asserted mid-operation SHALL lose in-flight loads and undrained stores with no output pulse.

Structure
REQ-031 Shared package SHALL hold default parameter values and the store-entry struct {valid, committed, addr, data}.
REQ-032 Store buffer (storage, commit, drain, forwarding search) SHALL be one sub-module, lsq_store_buffer; load pipe stays in top.

Verification
REQ-033 Store A=0x10 D=0x1234 tag 1, then load A=0x10 tag 2 -> no mem_rd_valid, res_valid at accept+3, res_tag=2, res_data=0x1234.
REQ-034 Stores 0x20<-0x1111 then 0x20<-0x2222, load 0x20 -> res_data=0x2222 (youngest wins).
REQ-035 Load 0x30 with empty buffer, mem_rdata=0xBEEF at accept+3 -> mem_rd_valid accept cycle, res_data=0xBEEF.
REQ-036 Fill 8 stores, no commit -> in_ready=0; commit_cnt=2 -> two mem_wr pulses in order, in_ready=1 cycle after first drain.
REQ-037 3 stores, commit_cnt=1, then flush with 2 loads in pipe -> one mem_wr of oldest store, no res_valid, buffer empty after.
REQ-038 rst_n low while 4 entries and 2 loads pending -> all outputs 0 immediately, in_ready=1, no writes after release.

Source files
------------

// File: rtl/load_store_queue_pkg.sv
// Shared defaults and the store-buffer entry layout for the load/store queue.
`timescale 1ns/1ps
package load_store_queue_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_ADDR_W   = 16;
  localparam int DEF_TAG_W    = 6;
  localparam int DEF_SB_DEPTH = 8;
  localparam int DEF_LOAD_LAT = 3;
  localparam int DEF_COMMIT_W = 2;

  // Entry fields are sized by the default widths; instances keep ADDR_W/DATA_W at these values.
  typedef struct packed {
    logic                  valid;
    logic                  committed;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/lsq_store_buffer.sv
// Circular store buffer: in-order commit, one drain per cycle, youngest-match load forwarding.
`timescale 1ns/1ps
module lsq_store_buffer
  import load_store_queue_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int SB_DEPTH = DEF_SB_DEPTH,
  parameter int COMMIT_W = DEF_COMMIT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic [COMMIT_W-1:0] commit_cnt,
  input  logic                push,
  input  logic [ADDR_W-1:0]   push_addr,
  input  logic [DATA_W-1:0]   push_data,
  input  logic [ADDR_W-1:0]   ld_addr,
  output logic                full,
  output logic                hit,
  output logic [DATA_W-1:0]   hit_data,
  output logic                wr_valid,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [DATA_W-1:0]   wr_data
);

  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CMP_W = (CNT_W > COMMIT_W) ? CNT_W : COMMIT_W;

  sb_entry_t        ent_q [SB_DEPTH];
  sb_entry_t        ent_d [SB_DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d, ccnt_q, ccnt_d;
  logic [CNT_W-1:0] ucnt, ncommit, keep, off;
  logic [PTR_W-1:0] off_p, srch_idx;
  logic [CMP_W-1:0] cc_w, uc_w;
  logic             drain;

  // Committed entries always form a prefix starting at head, so ccnt_q != 0 means head is drainable.
  assign full     = (count_q == CNT_W'(SB_DEPTH));
  assign drain    = (ccnt_q != '0);
  assign ucnt     = count_q - ccnt_q;
  assign wr_valid = drain;
  assign wr_addr  = drain ? ent_q[head_q].addr : '0;
  assign wr_data  = drain ? ent_q[head_q].data : '0;

  always_comb begin
    cc_w    = CMP_W'(commit_cnt);
    uc_w    = CMP_W'(ucnt);
    ncommit = (cc_w > uc_w) ? ucnt : CNT_W'(commit_cnt);
  end

  // Walk oldest to youngest so the last match seen is the youngest store.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    srch_idx = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      srch_idx = head_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && ent_q[srch_idx].valid &&
          (ent_q[srch_idx].addr == ld_addr)) begin
        hit      = 1'b1;
        hit_data = ent_q[srch_idx].data;
      end
    end
  end

  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    off_p   = '0;
    off     = '0;
    // Entries that stay committed after this edge, counted from the current head.
    keep    = ccnt_q + ncommit;
    for (int i = 0; i < SB_DEPTH; i++) begin
      off_p = PTR_W'(i) - head_q;
      off   = {1'b0, off_p};
      if ((off >= ccnt_q) && (off < keep)) ent_d[i].committed = 1'b1;
      if (flush && (off >= keep)) begin
        ent_d[i].valid     = 1'b0;
        ent_d[i].committed = 1'b0;
      end
      if (drain && (off == '0)) begin
        ent_d[i].valid     = 1'b0;
        ent_d[i].committed = 1'b0;
      end
    end
    if (drain) head_d = head_q + PTR_W'(1);
    ccnt_d  = keep - CNT_W'(drain);
    count_d = count_q - CNT_W'(drain);
    if (flush) begin
      count_d = ccnt_d;
      tail_d  = head_d + PTR_W'(ccnt_d);
    end
    if (push) begin
      ent_d[tail_q].valid     = 1'b1;
      ent_d[tail_q].committed = 1'b0;
      ent_d[tail_q].addr      = push_addr;
      ent_d[tail_q].data      = push_data;
      tail_d  = tail_q + PTR_W'(1);
      count_d = count_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ccnt_q  <= '0;
      for (int i = 0; i < SB_DEPTH; i++) ent_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ccnt_q  <= ccnt_d;
      for (int i = 0; i < SB_DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

endmodule

// File: rtl/load_store_queue.sv
// Load/store queue top: op acceptance, memory read launch and the fixed-latency load result pipe.
`timescale 1ns/1ps
module load_store_queue
  import load_store_queue_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int TAG_W    = DEF_TAG_W,
  parameter int SB_DEPTH = DEF_SB_DEPTH,
  parameter int LOAD_LAT = DEF_LOAD_LAT,
  parameter int COMMIT_W = DEF_COMMIT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic [COMMIT_W-1:0] commit_cnt,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_is_ld,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                mem_rd_valid,
  output logic [ADDR_W-1:0]   mem_rd_addr,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_wr_valid,
  output logic [ADDR_W-1:0]   mem_wr_addr,
  output logic [DATA_W-1:0]   mem_wr_data,
  output logic                res_valid,
  output logic [TAG_W-1:0]    res_tag,
  output logic [DATA_W-1:0]   res_data
);

  logic              accept, push, ld_acc, sb_full, sb_hit;
  logic [DATA_W-1:0] sb_hit_data;

  logic              ld_vld_q [LOAD_LAT];
  logic              ld_vld_d [LOAD_LAT];
  logic [TAG_W-1:0]  ld_tag_q [LOAD_LAT];
  logic [TAG_W-1:0]  ld_tag_d [LOAD_LAT];
  logic              ld_hit_q [LOAD_LAT];
  logic              ld_hit_d [LOAD_LAT];
  logic [DATA_W-1:0] ld_fwd_q [LOAD_LAT];
  logic [DATA_W-1:0] ld_fwd_d [LOAD_LAT];

  // rst_n gates acceptance so no read request escapes while reset is held.
  assign in_ready     = !sb_full;
  assign accept       = rst_n && in_valid && in_ready && !flush;
  assign push         = accept && !in_is_ld;
  assign ld_acc       = accept && in_is_ld;
  assign mem_rd_valid = ld_acc && !sb_hit;
  assign mem_rd_addr  = mem_rd_valid ? in_addr : '0;

  lsq_store_buffer #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .SB_DEPTH (SB_DEPTH),
    .COMMIT_W (COMMIT_W)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .commit_cnt (commit_cnt),
    .push       (push),
    .push_addr  (in_addr),
    .push_data  (in_data),
    .ld_addr    (in_addr),
    .full       (sb_full),
    .hit        (sb_hit),
    .hit_data   (sb_hit_data),
    .wr_valid   (mem_wr_valid),
    .wr_addr    (mem_wr_addr),
    .wr_data    (mem_wr_data)
  );

  always_comb begin
    ld_vld_d[0] = ld_acc;
    ld_tag_d[0] = in_tag;
    ld_hit_d[0] = sb_hit;
    ld_fwd_d[0] = sb_hit_data;
    for (int i = 1; i < LOAD_LAT; i++) begin
      ld_vld_d[i] = ld_vld_q[i-1];
      ld_tag_d[i] = ld_tag_q[i-1];
      ld_hit_d[i] = ld_hit_q[i-1];
      ld_fwd_d[i] = ld_fwd_q[i-1];
    end
    if (flush) begin
      for (int i = 0; i < LOAD_LAT; i++) ld_vld_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LOAD_LAT; i++) ld_vld_q[i] <= 1'b0;
    end else begin
      for (int i = 0; i < LOAD_LAT; i++) ld_vld_q[i] <= ld_vld_d[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LOAD_LAT; i++) begin
      ld_tag_q[i] <= ld_tag_d[i];
      ld_hit_q[i] <= ld_hit_d[i];
      ld_fwd_q[i] <= ld_fwd_d[i];
    end
  end

  // Output stage: memory data is taken live, exactly LOAD_LAT cycles after the read was launched.
  assign res_valid = ld_vld_q[LOAD_LAT-1];
  assign res_tag   = res_valid ? ld_tag_q[LOAD_LAT-1] : '0;
  assign res_data  = !res_valid ? '0 :
                     (ld_hit_q[LOAD_LAT-1] ? ld_fwd_q[LOAD_LAT-1] : mem_rdata);

endmodule
